// File: rtl/gf_inverse.sv
// Iterative GF(2^8) inverse (x^254 by square-and-multiply), inv(0) = 0.
// Feeds the forward S-box affine stage; one byte in flight, valid/ready on both sides.
module gf_inverse #(
  parameter logic [7:0] POLY  = 8'h1B,
  parameter int         ITERS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] idata,
  input  logic       ivalid,
  output logic       iready,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ITERS - 1);

  state_t     state;
  logic [7:0] base;
  logic [7:0] acc;
  logic [3:0] cnt;
  logic [7:0] sq;
  logic [7:0] prod;

  // MSB-first shift-and-add; reduction is folded in before each add so the
  // product never grows past 8 bits.
  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = p[7] ? ((p << 1) ^ POLY) : (p << 1);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  always_comb begin
    sq   = gfmul(base, base);
    prod = gfmul(acc, sq);
  end

  // base walks x^2, x^4, ... x^128 while acc gathers their product: x^254.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      iready <= 1'b0;
      ovalid <= 1'b0;
      odata  <= 8'h00;
      base   <= 8'h00;
      acc    <= 8'h00;
      cnt    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ivalid && iready) begin
            base   <= idata;
            acc    <= 8'h01;
            cnt    <= 4'd0;
            iready <= 1'b0;
            state  <= CALC;
          end else begin
            iready <= 1'b1;
          end
        end
        CALC: begin
          base <= sq;
          acc  <= prod;
          cnt  <= cnt + 4'd1;
          if (cnt == LAST) begin
            odata  <= prod;
            ovalid <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (oready) begin
            ovalid <= 1'b0;
            iready <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
